// File: rtl/mux_4_to_1.sv
// mux_4_to_1: 4:1 mux with optional registered output (enable with MUX_4_TO_1_REG_OUT_EN)
module mux_4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_vld
);
  logic [WIDTH-1:0] m0, m1;
  // two s0-selected pairs, then s1 picks between them
  always_comb begin
    m0 = s0 ? i1 : i0;
    m1 = s0 ? i3 : i2;
    y  = s1 ? m1 : m0;
  end
`ifdef MUX_4_TO_1_REG_OUT_EN
  logic [WIDTH-1:0] y_d;
  logic             y_vld_d, y_vld_q;
  // next registered value: load y when enabled, otherwise hold
  always_comb begin
    y_d     = en ? y : y_q;
    y_vld_d = en | y_vld_q;
  end
  // reset clears the register and the valid flag, and wins over en
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end
  assign y_vld = y_vld_q;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, en};
  assign y_q       = '0;
  assign y_vld     = 1'b0;
`endif
endmodule

// File: tb/tb_mux_4_to_1.sv
// tb_mux_4_to_1: directed-vector bench for mux_4_to_1 at WIDTH=1 and WIDTH=8
module tb_mux_4_to_1;
  logic       clk = 1'b0;
  logic       rst, en, s0, s1;
  logic       a_i0, a_i1, a_i2, a_i3, a_y, a_y_q, a_y_vld;
  logic [7:0] b_i0, b_i1, b_i2, b_i3, b_y, b_y_q;
  logic       b_y_vld;
  int         nvec = 0;
  int         nerr = 0;
  always #5 clk = ~clk;
  mux_4_to_1 #(.WIDTH(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
    .s0(s0), .s1(s1), .y(a_y), .y_q(a_y_q), .y_vld(a_y_vld)
  );
  mux_4_to_1 #(.WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
    .s0(s0), .s1(s1), .y(b_y), .y_q(b_y_q), .y_vld(b_y_vld)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] b_exp [4];
    b_exp[0] = 8'hA5;
    b_exp[1] = 8'h3C;
    b_exp[2] = 8'hF0;
    b_exp[3] = 8'h0F;
    rst = 1'b1;
    en  = 1'b0;
    s0  = 1'b0;
    s1  = 1'b0;
    {a_i0, a_i1, a_i2, a_i3} = 4'b1000;
    b_i0 = 8'hA5;
    b_i1 = 8'h3C;
    b_i2 = 8'hF0;
    b_i3 = 8'h0F;
    edge_wait();
    check("rst_y_q", {7'd0, a_y_q}, 8'h00);
    check("rst_vld", {7'd0, a_y_vld}, 8'h00);
    for (int s = 0; s < 4; s++) begin
      {s1, s0} = 2'(s);
      #5;
      check($sformatf("w1_sel%0d", s), {7'd0, a_y}, (s == 0) ? 8'h01 : 8'h00);
      check($sformatf("w8_sel%0d", s), b_y, b_exp[s]);
    end
    for (int k = 0; k < 4; k++) begin
      {a_i3, a_i2, a_i1, a_i0} = 4'(1 << k);
      for (int s = 0; s < 4; s++) begin
        {s1, s0} = 2'(s);
        #1;
        check($sformatf("onehot%0d_sel%0d", k, s), {7'd0, a_y}, (s == k) ? 8'h01 : 8'h00);
      end
    end
`ifdef MUX_4_TO_1_REG_OUT_EN
    {a_i3, a_i2, a_i1, a_i0} = 4'b0100;
    rst = 1'b1;
    en  = 1'b1;
    {s1, s0} = 2'b10;
    edge_wait();
    edge_wait();
    check("rsten_y_q1", {7'd0, a_y_q}, 8'h00);
    check("rsten_vld1", {7'd0, a_y_vld}, 8'h00);
    check("rsten_y_q8", b_y_q, 8'h00);
    check("rst_y_track", {7'd0, a_y}, 8'h01);
    check("rst_y8_track", b_y, 8'hF0);
    rst = 1'b0;
    edge_wait();
    check("load_y_q1", {7'd0, a_y_q}, 8'h01);
    check("load_vld1", {7'd0, a_y_vld}, 8'h01);
    check("load_y_q8", b_y_q, 8'hF0);
    check("load_vld8", {7'd0, b_y_vld}, 8'h01);
    en = 1'b0;
    {s1, s0} = 2'b00;
    #1;
    check("hold_y1_now", {7'd0, a_y}, 8'h00);
    check("hold_y8_now", b_y, 8'hA5);
    check("hold_y_q8_pre", b_y_q, 8'hF0);
    edge_wait();
    check("hold_y_q1", {7'd0, a_y_q}, 8'h01);
    check("hold_y_q8", b_y_q, 8'hF0);
    check("hold_vld", {7'd0, a_y_vld}, 8'h01);
    en = 1'b1;
    edge_wait();
    check("reload_y_q8", b_y_q, 8'hA5);
    check("reload_y_q1", {7'd0, a_y_q}, 8'h00);
    rst = 1'b1;
    #2;
    check("midrst_y_q8", b_y_q, 8'hA5);
    check("midrst_vld", {7'd0, b_y_vld}, 8'h01);
    edge_wait();
    check("rst_pri_y_q8", b_y_q, 8'h00);
    check("rst_pri_vld8", {7'd0, b_y_vld}, 8'h00);
    check("rst_pri_vld1", {7'd0, a_y_vld}, 8'h00);
`else
    rst = 1'b0;
    en  = 1'b1;
    {s1, s0} = 2'b00;
    edge_wait();
    edge_wait();
    check("tied_y_q8", b_y_q, 8'h00);
    check("tied_vld8", {7'd0, b_y_vld}, 8'h00);
    check("tied_y_q1", {7'd0, a_y_q}, 8'h00);
    check("tied_vld1", {7'd0, a_y_vld}, 8'h00);
    check("tied_y8", b_y, 8'hA5);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
